// File: rtl/hpdl_text_buffer.sv
// Character buffer and line editor feeding the HPDL-1414 scan driver.
// Folds UART bytes into the 64-char display set, applies edits, scrolls when full.
module hpdl_text_buffer #(
  parameter logic [6:0] BLANK      = 7'h20,
  parameter logic [6:0] CARET      = 7'h5F,
  parameter int         BLINK_BITS = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [3:0] rd_addr,
  output logic [6:0] rd_data,
  output logic [3:0] cursor,
  output logic       full,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_e;

  state_e                state_q, state_d;
  logic [6:0]            cells_q [16];
  logic [6:0]            cells_d [16];
  logic [3:0]            cursor_q, cursor_d;
  logic                  full_q, full_d;
  logic [3:0]            idx_q, idx_d;
  logic [6:0]            ch_q, ch_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [6:0]            rd_data_q, rd_data_d;

  logic       accept;
  logic       printable;
  logic [6:0] fold_ch;

  assign accept    = in_valid & in_ready;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  // Lower-case range 0x60-0x7E maps onto 0x40-0x5E by dropping bit 5.
  assign fold_ch   = {in_data[6], in_data[5] & ~in_data[6], in_data[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      for (int i = 0; i < 16; i++) cells_q[i] <= BLANK;
      cursor_q  <= 4'd0;
      full_q    <= 1'b0;
      idx_q     <= 4'd0;
      ch_q      <= BLANK;
      blink_q   <= '0;
      rd_data_q <= BLANK;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < 16; i++) cells_q[i] <= cells_d[i];
      cursor_q  <= cursor_d;
      full_q    <= full_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      blink_q   <= blink_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (printable && (cursor_q == 4'd15) && full_q) state_d = SCROLL;
          else if (in_data == 8'h0C)                       state_d = CLEAR;
        end
      end
      SCROLL:  if (idx_q == 4'd14) state_d = IDLE;
      CLEAR:   if (idx_q == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) cells_d[i] = cells_q[i];
    cursor_d = cursor_q;
    full_d   = full_q;
    idx_d    = idx_q;
    ch_d     = ch_q;
    case (state_q)
      IDLE: begin
        idx_d = 4'd0;
        if (accept) begin
          if (printable) begin
            if (cursor_q != 4'd15) begin
              cells_d[cursor_q] = fold_ch;
              cursor_d          = cursor_q + 4'd1;
            end else if (!full_q) begin
              cells_d[15] = fold_ch;
              full_d      = 1'b1;
            end else begin
              ch_d = fold_ch;
            end
          end else if (in_data == 8'h08) begin
            if (full_q) begin
              cells_d[15] = BLANK;
              full_d      = 1'b0;
            end else if (cursor_q != 4'd0) begin
              cursor_d                  = cursor_q - 4'd1;
              cells_d[cursor_q - 4'd1]  = BLANK;
            end
          end else if (in_data == 8'h0D) begin
            cursor_d = 4'd0;
            full_d   = 1'b0;
          end
        end
      end
      SCROLL: begin
        cells_d[idx_q] = cells_q[idx_q + 4'd1];
        idx_d          = idx_q + 4'd1;
        if (idx_q == 4'd14) begin
          cells_d[15] = ch_q;
          idx_d       = 4'd0;
        end
      end
      CLEAR: begin
        cells_d[idx_q] = BLANK;
        idx_d          = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          cursor_d = 4'd0;
          full_d   = 1'b0;
        end
      end
      default: idx_d = 4'd0;
    endcase
  end

  // Read sees pre-edge cells; caret only when the cursor cell is empty-to-be-typed.
  always_comb begin
    blink_d   = blink_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
    rd_data_d = cells_q[rd_addr];
    if ((rd_addr == cursor_q) && !full_q && blink_q[BLINK_BITS-1]) rd_data_d = CARET;
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    rd_data  = rd_data_q;
    cursor   = cursor_q;
    full     = full_q;
  end

endmodule

// File: doc/hpdl_text_buffer.md
# hpdl_text_buffer

Character buffer and line editor between the UART receiver and the HPDL-1414 scan driver. Consumes received bytes over a valid/ready handshake, folds them into the display's 64-character set, and applies the editing commands (backspace, carriage return, form feed) to a 16-cell, 7-bit buffer. When the line is full it scrolls left over multiple cycles. It exposes a registered random-access read port, with caret blink overlay, to the scan driver.

## Interface
- `BLANK`, default 7'h20: fill character for reset, clear and backspace.
- `CARET`, default 7'h5F: character overlaid at the cursor cell during the blink-on phase.
- `BLINK_BITS`, default 22: width of the free-running blink counter; its MSB is the blink phase.
- `clk`, in, 1: system clock (12 MHz).
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: `in_data` holds a byte.
- `in_data`, in, 8: received byte.
- `in_ready`, out, 1: block can accept a byte; equals (state==IDLE).
- `rd_addr`, in, 4: cell to read; 0 is leftmost.
- `rd_data`, out, 7: registered cell contents or caret.
- `cursor`, out, 4: next write position.
- `full`, out, 1: cell 15 holds a typed character.
- `busy`, out, 1: SCROLL or CLEAR in progress; equals ~in_ready.

## Operation
- Reset values:
  - all 16 cells = BLANK; cursor=0; full=0; state=IDLE.
  - blink counter=0; rd_data=BLANK; in_ready=1; busy=0.
- Accept: a byte is consumed at a rising edge with in_valid & in_ready. While busy, in_valid is ignored and the producer holds its data.
- Character fold: for 0x20–0x7E, if in_data[6:5]==2'b11, clear bit 5. Result is ch=in_data[6:0] in 0x20–0x5F, e.g. 'a'(0x61)→0x41 and '{'(0x7B)→0x5B.
- Printable byte (0x20–0x7E), IDLE:
  - If cursor<15: cell[cursor]<=ch; cursor<=cursor+1.
  - If cursor==15 and !full: cell[15]<=ch; full<=1; cursor stays 15.
  - If cursor==15 and full: latch ch and go to SCROLL.
- SCROLL:
  - A 4-bit index runs 0..14; each edge does cell[idx]<=cell[idx+1].
  - At idx 14 the same edge also does cell[15]<=latched ch, then the state returns to IDLE.
  - full stays 1 and cursor stays 15.
- Backspace 0x08:
  - If full: cell[15]<=BLANK; full<=0.
  - Else if cursor>0: cursor<=cursor-1; cell[cursor-1]<=BLANK.
  - Else: no-op, byte consumed.
- Carriage return 0x0D: cursor<=0; full<=0; cells unchanged.
- Form feed 0x0C: go to CLEAR. The index runs 0..15 and writes cell[idx]<=BLANK each edge. On the last edge: cursor<=0, full<=0, state IDLE.
- All other control bytes (0x00–0x1F excluding the above), 0x7F and 0x80–0xFF: consumed, no effect.
- Read, every edge:
  - rd_data <= (rd_addr==cursor && !full && blink_cnt[BLINK_BITS-1]) ? CARET : cell[rd_addr].
  - The read takes the pre-write value when the same cell is written on the same edge.
- Blink counter: free-running, wraps modulo 2^BLINK_BITS, unaffected by state.

## Timing
- Read latency: 1 cycle from rd_addr to rd_data.
- Simple write or edit: accepted at edge T, cell and cursor updated at T, visible on rd_data after edge T+1 for a matching rd_addr.
- SCROLL: in_ready is low for exactly 15 cycles after the accept edge. The final cell is written on the 15th edge; in_ready is high again in the following cycle.
- CLEAR: in_ready is low for exactly 16 cycles after the accept edge.
- Reset asserted mid-SCROLL or mid-CLEAR: immediate return to reset values. Partial shift and latched ch are discarded.
- A cursor wrap past 15 never occurs. Cursor arithmetic saturates at 15, and backspace saturates at 0.

## Test plan
- Reset, then read all 16 addresses with BLINK_BITS=4 and the blink phase off → every rd_data=0x20, cursor=0, full=0, in_ready=1.
- Send "hello" → cells 0–4 = 0x48,0x45,0x4C,0x4C,0x4F; cursor=5; in_ready never drops.
- Send 16 × 'A' then 'B' → full=1 after the 16th byte. in_ready is low for 15 cycles after 'B'; then cells 0–14=0x41, cell 15=0x42, cursor=15.
- At full, send 0x08 twice → first clears cell 15 (full=0, cursor=15), second gives cursor=14 and cell 14=0x20. At cursor=0, 0x08 changes nothing.
- Fill 10 cells, send 0x0C with in_valid held high on the next byte 'Z' → in_ready low 16 cycles, all cells 0x20. 'Z' is accepted afterwards into cell 0, cursor=1.
- BLINK_BITS=4, cursor=3, rd_addr=3 held → rd_data alternates between 0x5F and the cell value every 8 cycles. Repeat with full=1 → no caret shown.
